tcs_serial_comparator: RTL and testbench

Sequential, parametrised two's-complement/unsigned magnitude comparator. It is the next generation of the team's 8-bit combinational TCS comparator. Operands of `WIDTH` bits are captured on a start handshake and compared digit-by-digit from the MSB, `DIGIT` bits per cycle. The block returns registered `eq`/`gt`/`lt` flags with a one-cycle `done` pulse, for datapaths where a full-width combinational compare would break timing.

---
 rtl/tcs_serial_comparator.sv | 163 ++++++++++++++++
 tb/tb_tcs_serial_comparator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tcs_serial_comparator.sv
// Digit-serial magnitude comparator (unsigned / two's complement), MSB digit first.
// Optional macro TCS_CMP_EARLY_EXIT_EN ends the scan on the first differing digit.
module tcs_serial_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
`ifndef TCS_CMP_EARLY_EXIT_EN
  // First (MSB-most) differing digit and its direction, kept while the scan runs on.
  logic               found_q, found_d;
  logic               found_gt_q, found_gt_d;
  logic               any_diff, res_gt;
`endif

  logic [WIDTH-1:0]   a_cmp, b_cmp;
  logic [DIGIT-1:0]   dig_a, dig_b;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_cmp = mode_q ? (a_q ^ SIGN_MASK) : a_q;
  assign b_cmp = mode_q ? (b_q ^ SIGN_MASK) : b_q;
  assign dig_a = a_cmp[int'(idx_q)*DIGIT +: DIGIT];
  assign dig_b = b_cmp[int'(idx_q)*DIGIT +: DIGIT];

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
`ifndef TCS_CMP_EARLY_EXIT_EN
    found_d    = found_q;
    found_gt_d = found_gt_q;
    any_diff   = found_q || (dig_a != dig_b);
    res_gt     = found_q ? found_gt_q : (dig_a > dig_b);
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = signed_mode;
          idx_d   = IDX_TOP;
          state_d = ST_SCAN;
`ifndef TCS_CMP_EARLY_EXIT_EN
          found_d    = 1'b0;
          found_gt_d = 1'b0;
`endif
        end
      end

      ST_SCAN: begin
`ifdef TCS_CMP_EARLY_EXIT_EN
        if (dig_a != dig_b) begin
          eq_d    = 1'b0;
          gt_d    = (dig_a > dig_b);
          lt_d    = (dig_a < dig_b);
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
`else
        if (!found_q && (dig_a != dig_b)) begin
          found_d    = 1'b1;
          found_gt_d = (dig_a > dig_b);
        end
        if (idx_q == '0) begin
          eq_d    = !any_diff;
          gt_d    = any_diff && res_gt;
          lt_d    = any_diff && !res_gt;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: operand registers are reset too, so the block leaves reset in a fully known state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
`ifndef TCS_CMP_EARLY_EXIT_EN
      found_q    <= 1'b0;
      found_gt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
`ifndef TCS_CMP_EARLY_EXIT_EN
      found_q    <= found_d;
      found_gt_q <= found_gt_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_tcs_serial_comparator.sv
// Directed bench for tcs_serial_comparator (WIDTH=16, DIGIT=4); inputs driven and
// outputs sampled on the falling clock edge.
module tb_tcs_serial_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;
`ifdef TCS_CMP_EARLY_EXIT_EN
  localparam int LAT_MSB = 1;
`else
  localparam int LAT_MSB = N;
`endif

  logic             clk;
  logic             reset;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy, done, eq, gt, lt;

  int n_checks = 0;
  int n_pass   = 0;

  tcs_serial_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .eq          (eq),
    .gt          (gt),
    .lt          (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a start for one edge (E0), then scramble the operand inputs.
  task automatic start_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic mode);
    a           = av;
    b           = bv;
    signed_mode = mode;
    start       = 1'b1;
    next_cycle();
    start       = 1'b0;
    a           = WIDTH'($urandom);
    b           = WIDTH'($urandom);
    signed_mode = 1'($urandom);
  endtask

  // Wait (bounded) for done; 'elapsed' = edges already passed since E0.
  task automatic wait_result(input string tag, input logic e_eq, input logic e_gt,
                             input logic e_lt, input int e_lat, input int elapsed);
    int cyc = elapsed;
    while (done !== 1'b1 && cyc < 20) begin
      check({tag, "_busy_scan"}, busy, 1'b1);
      next_cycle();
      cyc++;
    end
    check({tag, "_latency"}, cyc, e_lat);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_flags"}, {eq, gt, lt}, {e_eq, e_gt, e_lt});
  endtask

  task automatic idle_after(input string tag, input logic e_eq, input logic e_gt,
                            input logic e_lt);
    next_cycle();
    check({tag, "_done_fall"}, done, 1'b0);
    check({tag, "_hold"}, {eq, gt, lt}, {e_eq, e_gt, e_lt});
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    #2;
    check("reset_state", {busy, done, eq, gt, lt}, 5'b0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    check("idle_after_reset", {busy, done, eq, gt, lt}, 5'b0);

    // Equal operands: full scan.
    start_cmp(16'h1234, 16'h1234, 1'b0);
    wait_result("equal", 1'b1, 1'b0, 1'b0, N, 0);
    idle_after("equal", 1'b1, 1'b0, 1'b0);

    // Sign handling.
    start_cmp(16'hFFFF, 16'h0001, 1'b1);
    wait_result("ffff_0001_signed", 1'b0, 1'b0, 1'b1, LAT_MSB, 0);
    idle_after("ffff_0001_signed", 1'b0, 1'b0, 1'b1);
    start_cmp(16'hFFFF, 16'h0001, 1'b0);
    wait_result("ffff_0001_unsigned", 1'b0, 1'b1, 1'b0, LAT_MSB, 0);
    idle_after("ffff_0001_unsigned", 1'b0, 1'b1, 1'b0);

    // Boundary values.
    start_cmp(16'h8000, 16'h7FFF, 1'b1);
    wait_result("8000_7fff_signed", 1'b0, 1'b0, 1'b1, LAT_MSB, 0);
    idle_after("8000_7fff_signed", 1'b0, 1'b0, 1'b1);
    start_cmp(16'h8000, 16'h7FFF, 1'b0);
    wait_result("8000_7fff_unsigned", 1'b0, 1'b1, 1'b0, LAT_MSB, 0);
    idle_after("8000_7fff_unsigned", 1'b0, 1'b1, 1'b0);

    // LSB-only difference always needs the full scan.
    start_cmp(16'h00A5, 16'h00A4, 1'b0);
    wait_result("lsb_diff", 1'b0, 1'b1, 1'b0, N, 0);
    idle_after("lsb_diff", 1'b0, 1'b1, 1'b0);

    // Start pulsed during SCAN is ignored.
    start_cmp(16'h0011, 16'h0012, 1'b0);
    check("ignore_busy_e0", busy, 1'b1);
    a     = 16'hFFFF;
    b     = 16'h0000;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    wait_result("ignore_start", 1'b0, 1'b0, 1'b1, N, 1);
    idle_after("ignore_start", 1'b0, 1'b0, 1'b1);

    // Start held in DONE: back-to-back compare.
    start_cmp(16'h0005, 16'h0005, 1'b0);
    wait_result("b2b_first", 1'b1, 1'b0, 1'b0, N, 0);
    a           = 16'h0003;
    b           = 16'h0009;
    signed_mode = 1'b0;
    start       = 1'b1;
    next_cycle();
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    check("b2b_no_done", done, 1'b0);
    check("b2b_hold_in_scan", {eq, gt, lt}, 3'b100);
    wait_result("b2b_second", 1'b0, 1'b0, 1'b1, N, 0);
    idle_after("b2b_second", 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-SCAN.
    start_cmp(16'h1234, 16'h1234, 1'b0);
    next_cycle();
    check("pre_reset_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, eq, gt, lt}, 5'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      next_cycle();
      check("no_stale_done", {busy, done}, 2'b00);
    end
    start_cmp(16'h8000, 16'h7FFF, 1'b1);
    wait_result("after_reset", 1'b0, 1'b0, 1'b1, LAT_MSB, 0);
    idle_after("after_reset", 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
